// File: rtl/autoc_peak_detect_pkg.sv
// Shared types for the autocorrelator chain: peak-detector FSM states and the
// width of an L1 magnitude built from two signed components.
package autoc_peak_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_TRACK   = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  // |I|+|Q| of two WIDTH-bit signed values needs exactly one extra bit.
  function automatic int mag_width(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/autoc_peak_detect_if.sv
// Sample-in / peak-out bus of the autocorrelation peak detector.
interface autoc_peak_detect_if #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 16
);
  localparam int MW = autoc_peak_detect_pkg::mag_width(WIDTH);

  // strobe_in qualifies si/sq for exactly one cycle and detect qualifies
  // peak_mag/peak_pos for one cycle; there is no ready, the consumer must
  // take every pulse. peak_mag/peak_pos also hold after detect drops.
  logic                    strobe_in;
  logic signed [WIDTH-1:0] si;
  logic signed [WIDTH-1:0] sq;
  logic                    detect;
  logic [MW-1:0]           peak_mag;
  logic [CNT_W-1:0]        peak_pos;

  modport master (output strobe_in, si, sq, input detect, peak_mag, peak_pos);
  modport slave  (input strobe_in, si, sq, output detect, peak_mag, peak_pos);

endinterface

// File: rtl/cmag_l1.sv
// Registered L1 magnitude |I|+|Q| of a signed complex sample, with a valid
// that follows the qualifying strobe by one cycle.
module cmag_l1
  import autoc_peak_detect_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_en,
  input  logic                           i_strobe,
  input  logic [WIDTH-1:0]               i_si,
  input  logic [WIDTH-1:0]               i_sq,
  output logic [mag_width(WIDTH)-1:0]    o_mag,
  output logic                           o_valid
);

  logic [WIDTH-1:0]            w_abs_i;
  logic [WIDTH-1:0]            w_abs_q;
  logic [mag_width(WIDTH)-1:0] w_sum;
  logic [mag_width(WIDTH)-1:0] r_mag;
  logic                        r_valid;

  // Two's-complement negate read as unsigned: the most negative input maps to
  // 2^(WIDTH-1) exactly, and the extra sum bit absorbs the carry.
  assign w_abs_i = i_si[WIDTH-1] ? (~i_si) + WIDTH'(1) : i_si;
  assign w_abs_q = i_sq[WIDTH-1] ? (~i_sq) + WIDTH'(1) : i_sq;
  assign w_sum   = {1'b0, w_abs_i} + {1'b0, w_abs_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_strobe & i_en;
      if (i_strobe & i_en) r_mag <= w_sum;
    end
  end

  assign o_mag   = r_mag;
  assign o_valid = r_valid;

endmodule

// File: rtl/autoc_peak_detect.sv
// Peak detector for autocorrelator output: arms after a run of above-threshold
// magnitudes, tracks the largest one, reports it when the run ends.
module autoc_peak_detect
  import autoc_peak_detect_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [mag_width(WIDTH)-1:0] threshold,
  input  logic [CNT_W-1:0]            min_run,
  input  logic [CNT_W-1:0]            holdoff,
  output logic                        busy,
  output state_t                      o_dbg_state,
  autoc_peak_detect_if.slave          bus
);

  localparam int MW = mag_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [MW-1:0]    w_mag;
  logic             w_mv;
  logic             w_above;
  logic [CNT_W-1:0] w_eff_min;
  logic [CNT_W-1:0] w_run_inc;
  logic [CNT_W-1:0] w_hold_inc;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_run, w_run_nxt;
  logic [CNT_W-1:0] r_hold, w_hold_nxt;
  logic [MW-1:0]    r_pk_mag, w_pk_mag_nxt;
  logic [CNT_W-1:0] r_pk_pos, w_pk_pos_nxt;
  logic             r_detect, w_det_nxt;
  logic [MW-1:0]    r_out_mag, w_out_mag_nxt;
  logic [CNT_W-1:0] r_out_pos, w_out_pos_nxt;
  logic [CNT_W-1:0] r_sidx;
  logic [CNT_W-1:0] r_sidx_d;

  cmag_l1 #(.WIDTH(WIDTH)) u_cmag (
    .clk     (clk),
    .rst     (rst),
    .i_en    (enable),
    .i_strobe(bus.strobe_in),
    .i_si    (bus.si),
    .i_sq    (bus.sq),
    .o_mag   (w_mag),
    .o_valid (w_mv)
  );

  // r_sidx is the index the next strobed sample will carry; r_sidx_d is the
  // index of the sample whose magnitude is currently valid.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_sidx   <= '0;
      r_sidx_d <= '0;
    end else if (bus.strobe_in) begin
      r_sidx   <= r_sidx + CNT_W'(1);
      r_sidx_d <= r_sidx;
    end
  end

  assign w_above    = (w_mag >= threshold);
  assign w_eff_min  = (min_run == '0) ? CNT_W'(1) : min_run;
  assign w_run_inc  = (r_run == CNT_MAX) ? r_run : r_run + CNT_W'(1);
  assign w_hold_inc = r_hold + CNT_W'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_run_nxt     = r_run;
    w_hold_nxt    = r_hold;
    w_pk_mag_nxt  = r_pk_mag;
    w_pk_pos_nxt  = r_pk_pos;
    w_det_nxt     = 1'b0;
    w_out_mag_nxt = r_out_mag;
    w_out_pos_nxt = r_out_pos;
    if (!enable) begin
      w_state_nxt  = ST_IDLE;
      w_run_nxt    = '0;
      w_hold_nxt   = '0;
      w_pk_mag_nxt = '0;
      w_pk_pos_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_mv && w_above) begin
          w_run_nxt = CNT_W'(1);
          if (CNT_W'(1) >= w_eff_min) begin
            w_state_nxt  = ST_TRACK;
            w_pk_mag_nxt = w_mag;
            w_pk_pos_nxt = r_sidx_d;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: if (w_mv) begin
          if (w_above) begin
            w_run_nxt = w_run_inc;
            if (w_run_inc >= w_eff_min) begin
              w_state_nxt  = ST_TRACK;
              w_pk_mag_nxt = w_mag;
              w_pk_pos_nxt = r_sidx_d;
            end
          end else begin
            w_run_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_TRACK: if (w_mv) begin
          // Strictly greater: on a tie the earlier index is kept.
          if (w_above) begin
            if (w_mag > r_pk_mag) begin
              w_pk_mag_nxt = w_mag;
              w_pk_pos_nxt = r_sidx_d;
            end
          end else begin
            w_det_nxt     = 1'b1;
            w_out_mag_nxt = r_pk_mag;
            w_out_pos_nxt = r_pk_pos;
            w_run_nxt     = '0;
            w_hold_nxt    = '0;
            w_state_nxt   = ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          if (holdoff == '0) begin
            w_state_nxt = ST_IDLE;
          end else if (w_mv) begin
            w_hold_nxt = w_hold_inc;
            if (w_hold_inc >= holdoff) begin
              w_hold_nxt  = '0;
              w_state_nxt = ST_IDLE;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_run     <= '0;
      r_hold    <= '0;
      r_pk_mag  <= '0;
      r_pk_pos  <= '0;
      r_detect  <= 1'b0;
      r_out_mag <= '0;
      r_out_pos <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_run     <= w_run_nxt;
      r_hold    <= w_hold_nxt;
      r_pk_mag  <= w_pk_mag_nxt;
      r_pk_pos  <= w_pk_pos_nxt;
      r_detect  <= w_det_nxt;
      r_out_mag <= w_out_mag_nxt;
      r_out_pos <= w_out_pos_nxt;
    end
  end

  assign bus.detect   = r_detect;
  assign bus.peak_mag = r_out_mag;
  assign bus.peak_pos = r_out_pos;
  assign busy         = (r_state != ST_IDLE);
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_autoc_peak_detect.sv
// Directed bench for autoc_peak_detect: hand-computed bursts, expected detects
// queued as {peak_mag, peak_pos} and matched by a detect monitor.
module tb_autoc_peak_detect;
  import autoc_peak_detect_pkg::*;

  localparam int W  = 24;
  localparam int CW = 16;
  localparam int MW = W + 1;
  localparam int EW = MW + CW;

  logic          clk;
  logic          rst;
  logic          enable;
  logic [MW-1:0] threshold;
  logic [CW-1:0] min_run;
  logic [CW-1:0] holdoff;
  logic          busy;
  state_t        dbg_state;

  autoc_peak_detect_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  autoc_peak_detect #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .threshold  (threshold),
    .min_run    (min_run),
    .holdoff    (holdoff),
    .busy       (busy),
    .o_dbg_state(dbg_state),
    .bus        (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int            checks    = 0;
  int            failures  = 0;
  logic [EW-1:0] exp_q[$];
  int            exp_total = 0;
  int            det_cnt   = 0;
  int unsigned   det_cyc   = 0;
  logic          prev_det  = 1'b0;

  always @(negedge clk) begin
    if (bus.detect === 1'b1) begin
      det_cnt = det_cnt + 1;
      det_cyc = cyc;
      checks  = checks + 1;
      assert (exp_q.size() > 0 && prev_det === 1'b0 &&
              {bus.peak_mag, bus.peak_pos} === exp_q[0])
      else begin
        failures = failures + 1;
        $error("FAIL detect_pulse: observed mag=%0d pos=%0d prev_det=%b, expected %0s",
               bus.peak_mag, bus.peak_pos, prev_det,
               (exp_q.size() > 0) ? $sformatf("mag=%0d pos=%0d", exp_q[0][EW-1:CW], exp_q[0][CW-1:0])
                                  : "no detect");
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    prev_det = bus.detect;
  end

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks = checks + 1;
    assert (observed === expected)
    else begin
      failures = failures + 1;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // ---------------- driver tasks ----------------
  logic [CW-1:0] idx      = '0;
  logic [CW-1:0] last_idx = '0;
  int unsigned   last_cyc = 0;

  task automatic smp_iq(input logic [W-1:0] i_v, input logic [W-1:0] q_v);
    bus.strobe_in = 1'b1;
    bus.si        = i_v;
    bus.sq        = q_v;
    last_idx      = idx;
    last_cyc      = cyc;
    if (enable && !rst) idx = idx + CW'(1);
    @(negedge clk);
  endtask

  // Splits a magnitude across a negative I and a positive Q.
  task automatic smp(input int m);
    smp_iq(W'(-(m / 2)), W'(m - m / 2));
  endtask

  task automatic gap(input int n);
    bus.strobe_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_det(input int m, input logic [CW-1:0] p);
    exp_q.push_back({MW'(m), p});
    exp_total = exp_total + 1;
  endtask

  task automatic zeros(input int n);
    repeat (n) smp(0);
    gap(2);
  endtask

  // ---------------- stimulus ----------------
  logic [CW-1:0] p;
  int            d0;

  initial begin
    rst = 1'b1; enable = 1'b0;
    bus.strobe_in = 1'b0; bus.si = '0; bus.sq = '0;
    threshold = MW'(1000); min_run = CW'(4); holdoff = CW'(8);
    repeat (3) @(negedge clk);
    chk("rst_detect", 64'(bus.detect), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_peak_mag", 64'(bus.peak_mag), 64'(0));
    chk("rst_peak_pos", 64'(bus.peak_pos), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0; enable = 1'b1; idx = '0;
    @(negedge clk);

    // Basic burst: 0, 1200 x6, 1500, 1100, 0 -> peak 1500 at index 7.
    smp(0);
    repeat (6) smp(1200);
    smp(1500); p = last_idx;
    smp(1100);
    expect_det(1500, p);
    smp(0);
    d0 = int'(last_cyc);
    gap(2);
    chk("basic_latency", 64'(int'(det_cyc) - d0), 64'(2));
    chk("basic_pos_is_7", 64'(bus.peak_pos), 64'(7));
    chk("basic_mag_held", 64'(bus.peak_mag), 64'(1500));
    chk("basic_pulse_low", 64'(bus.detect), 64'(0));
    chk("holdoff_state", 64'(dbg_state), 64'(ST_HOLDOFF));
    zeros(8);
    chk("holdoff_exit_busy", 64'(busy), 64'(0));

    // Short run: three above then one below never arms.
    d0 = det_cnt;
    repeat (3) smp(1200);
    gap(1);
    chk("short_run_state", 64'(dbg_state), 64'(ST_RUN));
    smp(0);
    gap(2);
    chk("short_run_busy", 64'(busy), 64'(0));
    chk("short_run_no_det", 64'(det_cnt - d0), 64'(0));

    // Equal peaks: the first 2000 wins.
    repeat (4) smp(1200);
    smp(2000); p = last_idx;
    smp(2000);
    smp(1100);
    expect_det(2000, p);
    smp(0);
    gap(3);
    chk("tie_first_pos", 64'(bus.peak_pos), 64'(p));

    // Burst starting on the 3rd strobe after detect lies inside holdoff.
    d0 = det_cnt;
    repeat (2) smp(0);
    repeat (5) smp(1200);
    zeros(3);
    chk("holdoff_ignored", 64'(det_cnt - d0), 64'(0));
    chk("holdoff_ignored_busy", 64'(busy), 64'(0));

    // Burst starting on the 10th strobe after detect is seen.
    repeat (4) smp(1200);
    smp(1500); p = last_idx;
    expect_det(1500, p);
    smp(0);
    gap(2);
    d0 = det_cnt;
    repeat (9) smp(0);
    repeat (3) smp(1200);
    smp(1200); p = last_idx;
    smp(1200);
    expect_det(1200, p);
    smp(0);
    gap(2);
    chk("after_holdoff_det", 64'(det_cnt - d0), 64'(1));
    zeros(8);

    // Threshold boundary: mag == threshold counts as above, 999 does not.
    repeat (3) smp(1000);
    smp(1000); p = last_idx;
    expect_det(1000, p);
    smp(999);
    gap(2);
    chk("thr_equal_mag", 64'(bus.peak_mag), 64'(1000));
    zeros(8);

    // min_run=0 arms on a single sample; holdoff=0 releases without strobes.
    min_run = '0; holdoff = '0;
    smp(1200); p = last_idx;
    expect_det(1200, p);
    smp(0);
    gap(4);
    chk("holdoff0_busy", 64'(busy), 64'(0));
    min_run = CW'(4); holdoff = CW'(8);

    // Most negative I and Q: magnitude exactly 2^24.
    repeat (3) smp_iq(W'(32'hFF80_0000), W'(32'hFF80_0000));
    smp_iq(W'(32'hFF80_0000), W'(32'hFF80_0000)); p = last_idx;
    expect_det(1 << 24, p);
    smp(0);
    gap(2);
    chk("extreme_mag", 64'(bus.peak_mag), 64'(1 << 24));
    zeros(8);

    // rst mid-TRACK: no detect, outputs cleared, next burst normal.
    d0 = det_cnt;
    repeat (5) smp(1200);
    gap(1);
    chk("rst_mid_state", 64'(dbg_state), 64'(ST_TRACK));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; idx = '0;
    gap(2);
    chk("rst_mid_no_det", 64'(det_cnt - d0), 64'(0));
    chk("rst_mid_mag", 64'(bus.peak_mag), 64'(0));
    chk("rst_mid_pos", 64'(bus.peak_pos), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    repeat (4) smp(1200);
    smp(1300); p = last_idx;
    expect_det(1300, p);
    smp(0);
    gap(2);
    chk("rst_next_pos", 64'(bus.peak_pos), 64'(4));
    zeros(8);

    // enable low mid-TRACK (with an ignored strobe): no detect, outputs held.
    d0 = det_cnt;
    repeat (5) smp(1200);
    gap(1);
    chk("en_mid_state", 64'(dbg_state), 64'(ST_TRACK));
    enable = 1'b0;
    bus.strobe_in = 1'b1; bus.si = W'(-2500); bus.sq = W'(2500);
    @(negedge clk);
    enable = 1'b1; idx = '0;
    gap(2);
    chk("en_mid_no_det", 64'(det_cnt - d0), 64'(0));
    chk("en_mid_mag_held", 64'(bus.peak_mag), 64'(1300));
    chk("en_mid_pos_held", 64'(bus.peak_pos), 64'(4));
    chk("en_mid_state_idle", 64'(dbg_state), 64'(ST_IDLE));
    repeat (4) smp(1200);
    smp(1400); p = last_idx;
    expect_det(1400, p);
    smp(0);
    gap(2);
    chk("en_next_pos", 64'(bus.peak_pos), 64'(4));
    zeros(8);

    // ---------------- final report ----------------
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
    chk("total_detects", 64'(det_cnt), 64'(exp_total));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
